// File: rtl/sys_clkgen_inferred.sv
`default_nettype none
// ============================================================================
// Module      : sys_clkgen_inferred
// Description : Technology-independent PLL stand-in. It models lock acquisition
//               and produces phase-aligned divided clock-enable and level
//               outputs on the input clock.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_clkgen_inferred #(
    parameter int CHANNELS    = 3,
    parameter int DIV_WIDTH   = 8,
    parameter int DIV_DEFAULT = 1,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                          i_clk,
    input  logic                          i_nrst,
    input  logic                          i_pll_rst,
    input  logic [CHANNELS*DIV_WIDTH-1:0] i_div,
    input  logic [CHANNELS-1:0]           i_div_update,
    output logic                          o_locked,
    output logic [CHANNELS-1:0]           o_clk_en,
    output logic [CHANNELS-1:0]           o_clk_div,
    output logic [CHANNELS-1:0]           o_div_busy
);
    localparam int                   c_lcw         = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [c_lcw-1:0]     c_lock_last   = c_lcw'(LOCK_CYCLES - 1);
    localparam logic [c_lcw-1:0]     c_lock_one    = c_lcw'(1);
    localparam logic [DIV_WIDTH-1:0] c_div_default = DIV_WIDTH'(DIV_DEFAULT);
    localparam logic [DIV_WIDTH-1:0] c_div_one     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH:0]   c_half_one    = {{DIV_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_lcw-1:0] r_lock_cnt;
    logic             w_locked;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state    <= ST_RST;
            r_lock_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_WAIT && w_state_nxt == ST_WAIT) begin
                r_lock_cnt <= r_lock_cnt + c_lock_one;
            end else begin
                r_lock_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RST:    if (!i_pll_rst) w_state_nxt = ST_WAIT;
            ST_WAIT:   if (r_lock_cnt == c_lock_last) w_state_nxt = ST_LOCKED;
            ST_LOCKED: w_state_nxt = ST_LOCKED;
            default:   w_state_nxt = ST_RST;
        endcase
        // The soft PLL reset overrides every state.
        if (i_pll_rst) w_state_nxt = ST_RST;
    end

    assign w_locked = (r_state == ST_LOCKED);
    assign o_locked = w_locked;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DIV_WIDTH-1:0] r_cnt;
        logic [DIV_WIDTH-1:0] r_act_div;
        logic [DIV_WIDTH-1:0] r_shd_div;
        logic                 r_pend;
        logic [DIV_WIDTH-1:0] w_d;
        logic                 w_wrap;
        logic [DIV_WIDTH:0]   w_half;

        assign w_d    = (r_act_div == '0) ? c_div_one : r_act_div;
        assign w_wrap = (r_cnt == w_d - c_div_one);
        assign w_half = ({1'b0, w_d} + c_half_one) >> 1;

        always_ff @(posedge i_clk) begin
            if (!i_nrst) begin
                r_cnt     <= '0;
                r_act_div <= c_div_default;
                r_shd_div <= c_div_default;
                r_pend    <= 1'b0;
            end else begin
                if (!w_locked) begin
                    r_cnt <= '0;
                    if (r_pend) begin
                        r_act_div <= r_shd_div;
                        r_pend    <= 1'b0;
                    end
                end else begin
                    r_cnt <= w_wrap ? '0 : r_cnt + c_div_one;
                    // Ratio changes land only on a period boundary.
                    if (w_wrap && r_pend) begin
                        r_act_div <= r_shd_div;
                        r_pend    <= 1'b0;
                    end
                end
                // A fresh capture wins over a same-edge apply.
                if (i_div_update[g]) begin
                    r_shd_div <= i_div[g*DIV_WIDTH +: DIV_WIDTH];
                    r_pend    <= 1'b1;
                end
            end
        end

        assign o_clk_en[g]   = w_locked & (r_cnt == '0);
        assign o_clk_div[g]  = w_locked & ({1'b0, r_cnt} < w_half);
        assign o_div_busy[g] = r_pend;
    end

endmodule
`default_nettype wire

// File: tb/tb_sys_clkgen_inferred.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_clkgen_inferred
// Description : Directed self-checking bench for sys_clkgen_inferred.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_clkgen_inferred;
    logic        clk;
    logic        nrst;
    logic        pll_rst;
    logic [23:0] div;
    logic [2:0]  upd;
    logic        locked;
    logic [2:0]  en;
    logic [2:0]  cdiv;
    logic [2:0]  busy;

    int checks   = 0;
    int failures = 0;

    sys_clkgen_inferred #(
        .CHANNELS    (3),
        .DIV_WIDTH   (8),
        .DIV_DEFAULT (1),
        .LOCK_CYCLES (16)
    ) dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_pll_rst    (pll_rst),
        .i_div        (div),
        .i_div_update (upd),
        .o_locked     (locked),
        .o_clk_en     (en),
        .o_clk_div    (cdiv),
        .o_div_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Check channel 1 in the current cycle, then advance one edge.
    task automatic cyc(input string tag, input logic e, input logic d, input logic b);
        chk({tag, "_en"},   32'(en[1]),   32'(e));
        chk({tag, "_div"},  32'(cdiv[1]), 32'(d));
        chk({tag, "_busy"}, 32'(busy[1]), 32'(b));
        tick(1);
    endtask

    initial begin
        logic [2:0] e;
        logic [2:0] d;

        nrst    = 1'b0;
        pll_rst = 1'b1;
        div     = '0;
        upd     = '0;
        tick(3);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_en",     32'(en),     32'd0);
        chk("rst_div",    32'(cdiv),   32'd0);
        chk("rst_busy",   32'(busy),   32'd0);

        // Load ratios {5,2,1} while unlocked; applied on the following edge.
        nrst = 1'b1;
        div  = {8'd5, 8'd2, 8'd1};
        upd  = 3'b111;
        tick(1);
        upd = 3'b000;
        chk("cap_busy",      32'(busy),   32'h7);
        chk("cap_locked",    32'(locked), 32'd0);
        tick(1);
        chk("unlocked_apply_busy", 32'(busy), 32'd0);

        // First edge sampling pll_rst=0 is edge k; lock appears after k+16.
        pll_rst = 1'b0;
        tick(16);
        chk("lock_early",    32'(locked), 32'd0);
        chk("lock_early_en", 32'(en),     32'd0);
        tick(1);
        chk("lock_rise",     32'(locked), 32'd1);
        chk("lock_rise_en",  32'(en),     32'h7);
        chk("lock_rise_div", 32'(cdiv),   32'h7);

        for (int t = 0; t < 20; t++) begin
            e = {(t % 5) == 0, (t % 2) == 0, 1'b1};
            d = {(t % 5) < 3,  (t % 2) < 1,  1'b1};
            chk("static_en",  32'(en),   32'(e));
            chk("static_div", 32'(cdiv), 32'(d));
            tick(1);
        end

        // ch1 currently at cnt=0 with d=2: move it to d=4.
        div[15:8] = 8'd4;
        upd = 3'b010;
        tick(1);
        upd = 3'b000;
        chk("to4_busy", 32'(busy[1]), 32'd1);
        tick(1);
        chk("to4_en",   32'(en[1]),   32'd1);
        chk("to4_idle", 32'(busy[1]), 32'd0);

        // Strobe 7 so it is captured as cnt becomes 1.
        div[15:8] = 8'd7;
        upd = 3'b010;
        cyc("d4_c0", 1'b1, 1'b1, 1'b0);
        upd = 3'b000;
        cyc("d4_c1", 1'b0, 1'b1, 1'b1);
        cyc("d4_c2", 1'b0, 1'b0, 1'b1);
        cyc("d4_c3", 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 14; j++) begin
            cyc("d7", (j % 7) == 0, (j % 7) < 4, 1'b0);
        end

        // Ratio 0 must behave as 1.
        div[15:8] = 8'd0;
        upd = 3'b010;
        cyc("z_c0", 1'b1, 1'b1, 1'b0);
        upd = 3'b000;
        for (int j = 1; j < 7; j++) begin
            cyc("z_wait", 1'b0, j < 4, 1'b1);
        end
        for (int j = 0; j < 3; j++) begin
            cyc("z_run", 1'b1, 1'b1, 1'b0);
        end

        // Bring ch1 to d=3.
        div[15:8] = 8'd3;
        upd = 3'b010;
        cyc("w_pre0", 1'b1, 1'b1, 1'b0);
        upd = 3'b000;
        cyc("w_pre1", 1'b1, 1'b1, 1'b1);
        // Strobe 4 at cnt 0, then 6 on the wrap edge: 4 applies, 6 stays pending.
        div[15:8] = 8'd4;
        upd = 3'b010;
        cyc("w3_c0", 1'b1, 1'b1, 1'b0);
        upd = 3'b000;
        cyc("w3_c1", 1'b0, 1'b1, 1'b1);
        div[15:8] = 8'd6;
        upd = 3'b010;
        cyc("w3_c2", 1'b0, 1'b0, 1'b1);
        upd = 3'b000;
        cyc("w4_c0", 1'b1, 1'b1, 1'b1);
        cyc("w4_c1", 1'b0, 1'b1, 1'b1);
        cyc("w4_c2", 1'b0, 1'b0, 1'b1);
        cyc("w4_c3", 1'b0, 1'b0, 1'b1);
        // Two strobes in one d=6 period: only 5 survives.
        div[15:8] = 8'd2;
        upd = 3'b010;
        cyc("w6_c0", 1'b1, 1'b1, 1'b0);
        upd = 3'b000;
        cyc("w6_c1", 1'b0, 1'b1, 1'b1);
        div[15:8] = 8'd5;
        upd = 3'b010;
        cyc("w6_c2", 1'b0, 1'b1, 1'b1);
        upd = 3'b000;
        cyc("w6_c3", 1'b0, 1'b0, 1'b1);
        cyc("w6_c4", 1'b0, 1'b0, 1'b1);
        cyc("w6_c5", 1'b0, 1'b0, 1'b1);
        cyc("w5_c0", 1'b1, 1'b1, 1'b0);
        cyc("w5_c1", 1'b0, 1'b1, 1'b0);
        cyc("w5_c2", 1'b0, 1'b1, 1'b0);
        cyc("w5_c3", 1'b0, 1'b0, 1'b0);
        cyc("w5_c4", 1'b0, 1'b0, 1'b0);
        cyc("w5_c5", 1'b1, 1'b1, 1'b0);

        // Three-cycle soft PLL reset while locked; ratios are now {5,5,1}.
        pll_rst = 1'b1;
        tick(1);
        chk("prst_locked", 32'(locked), 32'd0);
        chk("prst_en",     32'(en),     32'd0);
        chk("prst_div",    32'(cdiv),   32'd0);
        tick(2);
        pll_rst = 1'b0;
        tick(16);
        chk("relock_early", 32'(locked), 32'd0);
        tick(1);
        chk("relock_rise",  32'(locked), 32'd1);
        for (int t = 0; t < 10; t++) begin
            e = {(t % 5) == 0, (t % 5) == 0, 1'b1};
            d = {(t % 5) < 3,  (t % 5) < 3,  1'b1};
            chk("relock_en",  32'(en),   32'(e));
            chk("relock_div", 32'(cdiv), 32'(d));
            tick(1);
        end

        // Hard reset mid-LOCKED with an update pending, then mid-WAIT.
        div[15:8] = 8'd9;
        upd = 3'b010;
        tick(1);
        upd = 3'b000;
        chk("nrst_pre_busy", 32'(busy), 32'h2);
        nrst = 1'b0;
        tick(1);
        chk("nrstL_locked", 32'(locked), 32'd0);
        chk("nrstL_en",     32'(en),     32'd0);
        chk("nrstL_div",    32'(cdiv),   32'd0);
        chk("nrstL_busy",   32'(busy),   32'd0);
        nrst = 1'b1;
        tick(5);
        chk("midwait_locked", 32'(locked), 32'd0);
        nrst = 1'b0;
        tick(1);
        chk("nrstW_locked", 32'(locked), 32'd0);
        chk("nrstW_en",     32'(en),     32'd0);
        nrst = 1'b1;
        tick(16);
        chk("nrst_relock_early", 32'(locked), 32'd0);
        tick(1);
        chk("nrst_relock",     32'(locked), 32'd1);
        chk("nrst_relock_en",  32'(en),     32'h7);
        chk("nrst_relock_div", 32'(cdiv),   32'h7);
        tick(1);
        chk("default_en1",   32'(en),   32'h7);
        chk("default_div1",  32'(cdiv), 32'h7);
        chk("default_busy1", 32'(busy), 32'd0);
        tick(1);
        chk("default_en2",   32'(en),   32'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sys_clkgen_inferred.md
# sys_clkgen_inferred

Parametrised, technology-independent clock-generation model for behaviour simulation and FPGA-agnostic builds. It runs from a single input clock and models PLL lock acquisition with a programmable lock delay. It derives CHANNELS phase-aligned divided outputs, each a one-cycle clock-enable strobe plus a square-wave level, with a run-time programmable divide ratio. It sits at the top of the clock tree in place of a vendor PLL. Downstream logic stays on i_clk and qualifies with o_clk_en, so no derived clock nets are created.

## Interface
- CHANNELS, 3: number of divided output channels (1..16).
- DIV_WIDTH, 8: width of each divide ratio.
- DIV_DEFAULT, 1: divide ratio loaded into every channel on i_nrst.
- LOCK_CYCLES, 16: clock edges from PLL-reset release to lock (>=1).

- i_clk  in  1  system clock. All logic is on the rising edge.
- i_nrst  in  1  synchronous, active-low reset.
- i_pll_rst  in  1  soft PLL reset, active-high. Models the vendor RESET pin.
- i_div  in  CHANNELS*DIV_WIDTH  requested ratio. Channel i uses bits [i*DIV_WIDTH +: DIV_WIDTH].
- i_div_update  in  CHANNELS  per-channel strobe that captures the channel's i_div slice.
- o_locked  out  1  lock indicator.
- o_clk_en  out  CHANNELS  one-cycle strobe, once per divided period.
- o_clk_div  out  CHANNELS  divided square-wave level.
- o_div_busy  out  CHANNELS  the channel has a captured ratio that is not yet applied.

## Operation
- Lock FSM states: RST, WAIT, LOCKED.
  - i_nrst=0 forces the FSM to RST.
  - In any state, i_pll_rst=1 sends the FSM to RST at the next edge.
  - RST -> WAIT at the first edge that samples i_pll_rst=0. The lock counter is cleared at this edge.
  - In WAIT, the counter increments every edge. When the counter equals LOCK_CYCLES-1, the FSM moves to LOCKED.
  - o_locked = (state==LOCKED). The output is driven directly from the state register.
- Per-channel registers: cnt (DIV_WIDTH), act_div, shd_div, pend.
  - Effective ratio d = max(act_div, 1). A ratio of 0 is treated as 1.
- While not LOCKED:
  - cnt is held at 0.
  - o_clk_en and o_clk_div are 0.
  - A pending update is applied at the next edge (act_div<=shd_div, pend<=0).
- While LOCKED, each edge:
  - cnt <= (cnt==d-1) ? 0 : cnt+1.
  - On the wrap edge, if pend=1: act_div<=shd_div and pend<=0. The new ratio governs the period that starts with cnt=0.
- Outputs are combinational from the registers and gated by locked:
  - o_clk_en[i] = locked & (cnt==0).
  - o_clk_div[i] = locked & (cnt < (d+1)>>1). For d=2 this gives 50%. For odd d, the high phase is one cycle longer. For d=1, the output is constantly 1.
- i_div_update[i]=1 in any state: shd_div<=slice, pend<=1.
  - A second strobe before the wrap overwrites shd_div (last write wins).
  - A strobe on the same edge as the wrap wins. The old shd_div is applied, the new value is captured, and pend stays 1.
- o_div_busy = pend.
- All channels restart at cnt=0 on entry to LOCKED, so their first strobes coincide with the o_locked rise. Channels stay mutually phase-aligned at common multiples of their ratios.

## Timing
- Reset values (i_nrst=0): state=RST, lock counter=0, cnt=0, act_div=shd_div=DIV_DEFAULT, pend=0.
  - Therefore o_locked=0, o_clk_en=0, o_clk_div=0, o_div_busy=0.
- Lock latency: if edge k is the first edge sampling i_pll_rst=0, o_locked rises after edge k+LOCK_CYCLES.
- First o_clk_en pulse: in the same cycle that o_locked rises.
- i_pll_rst=1 mid-operation: o_locked, o_clk_en and o_clk_div drop after the sampling edge. act_div is kept, and pending updates are applied while unlocked.
- Ratio change latency while locked: up to d cycles. The change takes effect at the first wrap after capture, and no period is ever truncated.
- Counter width: d up to 2^DIV_WIDTH-1. cnt never exceeds d-1.

## Test plan
- Lock delay: LOCK_CYCLES=16, release i_pll_rst at edge 10 -> o_locked rises after edge 26, and o_clk_en=all-ones in that cycle.
- Static ratios {1,2,5}, locked for 20 cycles ->
  - ch0: en every cycle, div=1.
  - ch1: en every 2nd cycle, div pattern 1,0.
  - ch2: en every 5th cycle, div pattern 1,1,1,0,0.
  - All three en pulses coincide every 10 cycles.
- Glitch-free update: ch1 at d=4, strobe ratio 7 when cnt=1 -> o_div_busy=1 for 3 cycles. The current period completes at 4 cycles, then the periods are 7 cycles with 4-high/3-low.
- Boundary cases:
  - A ratio of 0 behaves as 1.
  - A strobe on the wrap edge is applied one period later.
  - Two strobes within one period apply only the last value.
- i_pll_rst pulse of 3 cycles while locked -> outputs are 0 from the next edge. They relock LOCKED_CYCLES edges after release with the retained ratios, and all cnt restart phase-aligned.
- i_nrst=0 asserted mid-WAIT and mid-LOCKED -> all outputs are 0 at the next edge, and every channel's act_div returns to DIV_DEFAULT.
